// File: rtl/scic_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the SCIC accumulator processor.
// Registered state; every datapath strobe is decoded combinationally from state and opcode.
module scic_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int STATE_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                acc_zero,
    input  logic                acc_neg,
    output logic                mar_sel,
    output logic                mar_load,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                acc_load,
    output logic [1:0]          acc_src,
    output logic [1:0]          alu_op,
    output logic                led_load,
    output logic                illegal,
    output logic                halted,
    output logic [STATE_W-1:0]  state
);

    localparam logic [STATE_W-1:0] S_IDLE       = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH_ADDR = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_FETCH_READ = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_DECODE     = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_EXEC_ADDR  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_EXEC_MEM   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC_WB    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_HALT       = STATE_W'(7);

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_JN    = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_OUT   = OPCODE_W'(4'h9);
    localparam logic [OPCODE_W-1:0] OP_IN    = OPCODE_W'(4'hA);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4'hF);

    localparam logic [1:0] SRC_MEM = 2'b00;
    localparam logic [1:0] SRC_ALU = 2'b01;
    localparam logic [1:0] SRC_SW  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               is_mem_op;
    logic               is_store;
    logic [STATE_W-1:0] boundary_next;

    assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                       (opcode == OP_ADD)  || (opcode == OP_SUB)   ||
                       (opcode == OP_AND);
    assign is_store  = (opcode == OP_STORE);

    // Dropping run only stops the machine at an instruction boundary.
    assign boundary_next = run ? S_FETCH_ADDR : S_IDLE;

    // NOTE: every variable gets a default at the top of the always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = run ? S_FETCH_ADDR : S_IDLE;
            S_FETCH_ADDR: state_d = S_FETCH_READ;
            S_FETCH_READ: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_mem_op) begin
                    state_d = S_EXEC_ADDR;
                end else begin
                    state_d = boundary_next;
                end
            end
            S_EXEC_ADDR:  state_d = S_EXEC_MEM;
            S_EXEC_MEM:   state_d = is_store ? boundary_next : S_EXEC_WB;
            S_EXEC_WB:    state_d = boundary_next;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mar_sel   = 1'b0;
        mar_load  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_load  = 1'b0;
        acc_src   = SRC_MEM;
        alu_op    = ALU_ADD;
        led_load  = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH_ADDR: begin
                mar_sel  = 1'b0;
                mar_load = 1'b1;
            end
            S_FETCH_READ: begin
                mem_read = 1'b1;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JMP: pc_load  = 1'b1;
                    OP_JZ:  pc_load  = acc_zero;
                    OP_JN:  pc_load  = acc_neg;
                    OP_OUT: led_load = 1'b1;
                    OP_IN: begin
                        acc_load = 1'b1;
                        acc_src  = SRC_SW;
                    end
                    OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_HALT: ;
                    default: illegal = 1'b1;
                endcase
            end
            S_EXEC_ADDR: begin
                mar_sel  = 1'b1;
                mar_load = 1'b1;
            end
            S_EXEC_MEM: begin
                mem_write = is_store;
                mem_read  = !is_store;
            end
            S_EXEC_WB: begin
                acc_load = 1'b1;
                case (opcode)
                    OP_ADD: begin
                        acc_src = SRC_ALU;
                        alu_op  = ALU_ADD;
                    end
                    OP_SUB: begin
                        acc_src = SRC_ALU;
                        alu_op  = ALU_SUB;
                    end
                    OP_AND: begin
                        acc_src = SRC_ALU;
                        alu_op  = ALU_AND;
                    end
                    default: acc_src = SRC_MEM;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_scic_control_unit.sv
// Scoreboard bench for scic_control_unit: the driver pushes the expected per-cycle
// output trace of each instruction, a negedge monitor pops and compares.
module tb_scic_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic       acc_zero;
    logic       acc_neg;
    logic       mar_sel, mar_load, mem_read, mem_write, ir_load, pc_inc, pc_load, acc_load;
    logic [1:0] acc_src, alu_op;
    logic       led_load, illegal, halted;
    logic [2:0] state;

    scic_control_unit #(.OPCODE_W(4), .STATE_W(3)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .acc_zero(acc_zero), .acc_neg(acc_neg),
        .mar_sel(mar_sel), .mar_load(mar_load), .mem_read(mem_read), .mem_write(mem_write),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load),
        .acc_src(acc_src), .alu_op(alu_op), .led_load(led_load), .illegal(illegal),
        .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       mar_sel, mar_load, mem_read, mem_write, ir_load, pc_inc, pc_load, acc_load;
        logic [1:0] acc_src, alu_op;
        logic       led_load, illegal, halted;
    } rec_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [2:0] st);
        rec_t r;
        r    = '0;
        r.st = st;
        return r;
    endfunction

    function automatic rec_t actual();
        rec_t r;
        r = '{state, mar_sel, mar_load, mem_read, mem_write, ir_load, pc_inc, pc_load,
              acc_load, acc_src, alu_op, led_load, illegal, halted};
        return r;
    endfunction

    // Cycle-by-cycle trace of one instruction as the programmer's model describes it.
    function automatic int push_trace(input logic [3:0] op, input logic az, input logic an,
                                      input int limit);
        rec_t t[$];
        rec_t r;
        int   n;
        r = mk(3'd1); r.mar_load = 1'b1; t.push_back(r);
        r = mk(3'd2); r.mem_read = 1'b1; r.ir_load = 1'b1; r.pc_inc = 1'b1; t.push_back(r);
        r = mk(3'd3);
        case (op)
            4'h6: r.pc_load = 1'b1;
            4'h7: r.pc_load = az;
            4'h8: r.pc_load = an;
            4'h9: r.led_load = 1'b1;
            4'hA: begin r.acc_load = 1'b1; r.acc_src = 2'b10; end
            4'hB, 4'hC, 4'hD, 4'hE: r.illegal = 1'b1;
            default: ;
        endcase
        t.push_back(r);
        if (op >= 4'h1 && op <= 4'h5) begin
            r = mk(3'd4); r.mar_sel = 1'b1; r.mar_load = 1'b1; t.push_back(r);
            r = mk(3'd5);
            if (op == 4'h2) r.mem_write = 1'b1;
            else            r.mem_read  = 1'b1;
            t.push_back(r);
            if (op != 4'h2) begin
                r = mk(3'd6);
                r.acc_load = 1'b1;
                if (op != 4'h1) begin
                    r.acc_src = 2'b01;
                    r.alu_op  = 2'(op - 4'h3);
                end
                t.push_back(r);
            end
        end
        n = 0;
        foreach (t[i]) begin
            if (i < limit) begin
                exp_q.push_back(t[i]);
                n++;
            end
        end
        return n;
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from state updates.
    always @(negedge clock) begin
        rec_t e;
        rec_t a;
        if (reset === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            check($sformatf("cycle_st%0d", e.st), 32'(a), 32'(e));
            check("rd_wr_excl", 32'(a.mem_read & a.mem_write), 32'd0);
            check("inc_load_excl", 32'(a.pc_inc & a.pc_load), 32'd0);
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic idle_cycle(input bit run_v);
        exp_q.push_back(mk(3'd0));
        run      = run_v;
        opcode   = 4'($urandom);
        acc_zero = 1'($urandom);
        acc_neg  = 1'($urandom);
        @(posedge clock); #1;
    endtask

    task automatic exec_instr(input logic [3:0] op, input bit az, input bit an, input bit last_run);
        int n;
        n = push_trace(op, az, an, 99);
        for (int i = 0; i < n; i++) begin
            opcode   = (i == 0) ? 4'($urandom) : op;
            acc_zero = (i == 2) ? az : 1'($urandom);
            acc_neg  = (i == 2) ? an : 1'($urandom);
            run      = (i == n - 1) ? last_run : 1'($urandom);
            @(posedge clock); #1;
        end
    endtask

    task automatic halt_cycles(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = mk(3'd7); r.halted = 1'b1;
            exp_q.push_back(r);
            run    = (i % 2 == 0);
            opcode = 4'($urandom);
            @(posedge clock); #1;
        end
    endtask

    task automatic reset_in_exec_mem(input logic [3:0] op);
        void'(push_trace(op, 1'b0, 1'b0, 5));
        opcode = op;
        run    = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock); #1;
        check("queue_before_reset", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_reset_state", 32'(state), 32'd0);
        check("mid_reset_mem_read", 32'(mem_read), 32'd0);
        check("mid_reset_outputs", 32'(actual()), 32'(mk(3'd0)));
        run = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        bit         lr;
        reset    = 1'b0;
        run      = 1'b0;
        opcode   = 4'h0;
        acc_zero = 1'b0;
        acc_neg  = 1'b0;
        #3;
        check("in_reset_outputs", 32'(actual()), 32'(mk(3'd0)));
        #4 reset = 1'b1;
        #1;
        check("after_release_state", 32'(state), 32'd0);
        @(posedge clock); #1;

        idle_cycle(1'b0);
        idle_cycle(1'b1);
        exec_instr(4'h1, 1'b0, 1'b0, 1'b1);
        exec_instr(4'h7, 1'b1, 1'b0, 1'b1);
        exec_instr(4'h7, 1'b0, 1'b1, 1'b1);
        exec_instr(4'h8, 1'b0, 1'b1, 1'b1);
        exec_instr(4'h2, 1'b1, 1'b1, 1'b1);
        exec_instr(4'h4, 1'b0, 1'b0, 1'b1);
        exec_instr(4'hC, 1'b0, 1'b0, 1'b1);
        exec_instr(4'hA, 1'b0, 1'b0, 1'b1);
        exec_instr(4'h3, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 14));
            lr = ($urandom_range(0, 3) != 0);
            exec_instr(op, 1'($urandom), 1'($urandom), lr);
            if (!lr) begin
                repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
                idle_cycle(1'b1);
            end
        end

        reset_in_exec_mem(4'h1);
        idle_cycle(1'b1);

        exec_instr(4'hF, 1'b0, 1'b0, 1'b0);
        halt_cycles(20);
        @(negedge clock); #1;
        reset = 1'b0;
        run   = 1'b0;
        #1;
        check("halt_reset_outputs", 32'(actual()), 32'(mk(3'd0)));
        @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); #1;
        idle_cycle(1'b0);
        @(negedge clock); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scic_control_unit.md
Name: scic_control_unit

Overview:
Multi-cycle control FSM for the SCIC accumulator processor inside `system`. It sequences PC, IR, MAR, memory, accumulator and the LED output register through fetch/decode/execute. It decodes the 4-bit opcode held in IR and drives one-hot-style control strobes to the datapath.

Parameters:
OPCODE_W, 4, opcode width from IR[7:4]; the decode table below is fixed for 4.
STATE_W, 3, width of the encoded state register exported on `state`.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous active-low reset; clears FSM to IDLE.
run  input  1  level; starts execution from IDLE.
opcode  input  OPCODE_W  IR[7:4]; valid from DECODE onward.
acc_zero  input  1  accumulator == 0.
acc_neg  input  1  accumulator MSB.
mar_sel  output  1  0: MAR<=PC, 1: MAR<=IR[3:0].
mar_load  output  1  load MAR.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe (ACC -> mem[MAR]).
ir_load  output  1  IR<=mem data.
pc_inc  output  1  PC<=PC+1.
pc_load  output  1  PC<=IR[3:0].
acc_load  output  1  load accumulator.
acc_src  output  2  00 mem data, 01 ALU, 10 switches.
alu_op  output  2  00 ADD, 01 SUB, 10 AND.
led_load  output  1  LED reg<=ACC[3:0].
illegal  output  1  one-cycle pulse on undefined opcode.
halted  output  1  high in HALT state.
state  output  STATE_W  current state, debug.

Behaviour:
- States/encodings: IDLE=0, FETCH_ADDR=1, FETCH_READ=2, DECODE=3, EXEC_ADDR=4, EXEC_MEM=5, EXEC_WB=6, HALT=7.
- Outputs are combinational from registered state and `opcode`. All strobes are 0 unless listed below. acc_src and alu_op default to 00.
- reset low (asynchronous): state=IDLE, all outputs 0. Takes effect mid-instruction with no completion.
- IDLE: go to FETCH_ADDR when run=1, otherwise stay.
- FETCH_ADDR: mar_sel=0, mar_load=1. Next state FETCH_READ.
- FETCH_READ: mem_read=1, ir_load=1, pc_inc=1. Next state DECODE.
- DECODE, by opcode:
  - 0 NOP: no strobes.
  - 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND: next state EXEC_ADDR.
  - 6 JMP: pc_load=1.
  - 7 JZ: pc_load=acc_zero.
  - 8 JN: pc_load=acc_neg.
  - 9 OUT: led_load=1.
  - A IN: acc_load=1, acc_src=10.
  - F HALT: next state HALT.
  - B–E: illegal=1, otherwise treated as NOP.
  - Unless stated otherwise, next state after DECODE is FETCH_ADDR, or IDLE if run=0 (stop only at instruction boundary).
- EXEC_ADDR: mar_sel=1, mar_load=1. Next state EXEC_MEM.
- EXEC_MEM: STORE drives mem_write=1 and then goes to the next-fetch/IDLE rule. Other opcodes drive mem_read=1 and go to EXEC_WB.
- EXEC_WB: acc_load=1.
  - LOAD: acc_src=00.
  - ADD/SUB/AND: acc_src=01, with alu_op=00/01/10 respectively.
  - Then apply the next-fetch/IDLE rule.
- The next-fetch/IDLE rule is evaluated at the last cycle of every instruction: run=1 goes to FETCH_ADDR, run=0 goes to IDLE.
- HALT: halted=1, stays until reset. run is ignored.
- Latency: NOP/JMP/JZ/JN/OUT/IN/illegal take 3 cycles; STORE takes 5; LOAD/ADD/SUB/AND take 6.
- Never assert mem_read and mem_write together. Never assert pc_inc and pc_load together.
- Opcode changing outside DECODE/EXEC has no effect; IR is only reloaded in FETCH_READ.

Test Plan:
- Reset: hold reset=0 for 7 ns, release, run=0 -> state=0, all outputs 0; run=1 -> state=1 on the next edge.
- LOAD sequence: run=1, opcode=1 -> states 1,2,3,4,5,6,1. acc_load=1 with acc_src=00 in state 6 only, and exactly 6 cycles per instruction.
- Branches: JZ (opcode=7) with acc_zero=1 -> pc_load=1 in DECODE. With acc_zero=0 -> pc_load=0. JN with acc_neg=1 -> pc_load=1. Each branch takes 3 cycles.
- STORE then SUB: opcode=2 -> mem_write=1 only in state 5, then FETCH_ADDR. Opcode=4 -> alu_op=01, acc_src=01 in state 6.
- Illegal/HALT: opcode=C -> illegal high exactly 1 cycle, back to state 1. Opcode=F -> halted=1 and state=7 held for 20 cycles despite run toggling.
- Reset and stop: reset=0 asserted in EXEC_MEM -> immediate state=0 with mem_read=0. Separately, run dropped during an ADD -> instruction completes, then state=0.
